// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the FIFO push arbiter.
//   arb_state_e : arbiter FSM state (ARB_LOCK only reachable with FIFO_ARB_BURST_EN)
//   MAX_NREQ    : upper bound on the number of requesters
//   idx_w()     : index width for a count of n items (never below 1)
package fifo_arb_pkg;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_LOCK = 1'b1
  } arb_state_e;

  localparam int unsigned MAX_NREQ = 8;

  function automatic int unsigned idx_w(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin picker: first set bit of req, searching from
// rr_ptr upward and wrapping modulo NREQ.
//   req       in  NREQ   request vector
//   rr_ptr    in  IDX_W  highest-priority index this cycle (< NREQ)
//   grant_oh  out NREQ   one-hot winner (zero when no request)
//   grant_idx out IDX_W  winner index (zero when no request)
//   grant_any out 1      at least one request present
module rr_priority_picker
  import fifo_arb_pkg::*;
#(
  parameter int unsigned NREQ  = 3,
  parameter int unsigned IDX_W = idx_w(NREQ)
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] rr_ptr,
  output logic [NREQ-1:0]  grant_oh,
  output logic [IDX_W-1:0] grant_idx,
  output logic             grant_any
);

  localparam int unsigned P_W = IDX_W + 1;

  logic [P_W-1:0] pos;

  // Scan NREQ positions starting at rr_ptr; the first hit wins.
  always_comb begin
    grant_oh  = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    pos       = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      pos = {1'b0, rr_ptr} + P_W'(k);
      if (pos >= P_W'(NREQ)) pos = pos - P_W'(NREQ);
      if (!grant_any && req[pos[IDX_W-1:0]]) begin
        grant_any                = 1'b1;
        grant_idx                = pos[IDX_W-1:0];
        grant_oh[pos[IDX_W-1:0]] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_push_arbiter.sv
// Round-robin arbiter sharing one synchronous FIFO write port among NREQ
// producers. Zero-latency valid/ready toward producers; push is suppressed
// while the FIFO reports full.
// Optional feature macro: FIFO_ARB_BURST_EN (locked multi-beat grants of up
// to MAX_BURST beats, terminated by req_last_i or the beat limit).
//   clk, reset   clock; synchronous active-low reset
//   req_valid_i  per-requester beat valid
//   req_last_i   per-requester last-beat flag (burst mode only)
//   req_data_i   packed requester data, requester i at [i*DATA_W +: DATA_W]
//   req_ready_o  per-requester accept (at most one bit high)
//   fifo_full_i  FIFO full flag
//   push_o       FIFO push strobe
//   push_data_o  FIFO push data (zero when not pushing)
//   grant_id_o   current winner index (debug)
module fifo_push_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int unsigned NREQ      = 3,
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned MAX_BURST = 4,
  parameter int unsigned IDX_W     = idx_w(NREQ)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NREQ-1:0]        req_valid_i,
  input  logic [NREQ-1:0]        req_last_i,
  input  logic [NREQ*DATA_W-1:0] req_data_i,
  output logic [NREQ-1:0]        req_ready_o,
  input  logic                   fifo_full_i,
  output logic                   push_o,
  output logic [DATA_W-1:0]      push_data_o,
  output logic [IDX_W-1:0]       grant_id_o
);

  localparam int unsigned CNT_W = idx_w(MAX_BURST + 1);

  arb_state_e       state, state_nxt;
  logic [IDX_W-1:0] rr_ptr, rr_ptr_nxt;
  logic [IDX_W-1:0] owner, owner_nxt;
  logic [CNT_W-1:0] beat_cnt, beat_cnt_nxt, cnt_inc;

  logic [NREQ-1:0]  pick_oh;
  logic [IDX_W-1:0] pick_idx;
  logic             pick_any;
  logic [IDX_W-1:0] win_idx;
  logic             win_valid;
  logic             accept;

  function automatic logic [IDX_W-1:0] inc_wrap(input logic [IDX_W-1:0] w);
    return (w == IDX_W'(NREQ - 1)) ? '0 : w + IDX_W'(1);
  endfunction

  rr_priority_picker #(
    .NREQ (NREQ),
    .IDX_W(IDX_W)
  ) u_picker (
    .req      (req_valid_i),
    .rr_ptr   (rr_ptr),
    .grant_oh (pick_oh),
    .grant_idx(pick_idx),
    .grant_any(pick_any)
  );

  // Winner selection, handshake outputs and next-state logic.
  always_comb begin
    state_nxt    = state;
    rr_ptr_nxt   = rr_ptr;
    owner_nxt    = owner;
    beat_cnt_nxt = beat_cnt;
    cnt_inc      = beat_cnt + CNT_W'(1);
    win_idx      = pick_idx;
    win_valid    = pick_any;
    req_ready_o  = '0;
    push_data_o  = '0;

    // A locked grant ignores everyone but the owner, even if it idles.
    if (state == ARB_LOCK) begin
      win_idx   = owner;
      win_valid = req_valid_i[owner];
    end

    accept = reset && win_valid && !fifo_full_i;
    push_o = accept;

    if (accept) begin
      req_ready_o = (state == ARB_LOCK) ? (NREQ'(1) << owner) : pick_oh;
      for (int unsigned i = 0; i < NREQ; i++) begin
        if (IDX_W'(i) == win_idx) push_data_o = req_data_i[i*DATA_W +: DATA_W];
      end
    end

    grant_id_o = reset ? win_idx : '0;

    case (state)
      ARB_IDLE: begin
        if (accept) begin
`ifdef FIFO_ARB_BURST_EN
          if (!req_last_i[win_idx] && MAX_BURST > 1) begin
            state_nxt    = ARB_LOCK;
            owner_nxt    = win_idx;
            beat_cnt_nxt = CNT_W'(1);
          end else begin
            rr_ptr_nxt = inc_wrap(win_idx);
          end
`else
          rr_ptr_nxt = inc_wrap(win_idx);
`endif
        end
      end
      ARB_LOCK: begin
        if (accept) begin
          if (req_last_i[owner] || cnt_inc >= CNT_W'(MAX_BURST)) begin
            state_nxt    = ARB_IDLE;
            rr_ptr_nxt   = inc_wrap(owner);
            beat_cnt_nxt = '0;
          end else begin
            beat_cnt_nxt = cnt_inc;
          end
        end
      end
      default: state_nxt = ARB_IDLE;
    endcase
  end

  // Arbiter state registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= ARB_IDLE;
      rr_ptr   <= '0;
      owner    <= '0;
      beat_cnt <= '0;
    end else begin
      state    <= state_nxt;
      rr_ptr   <= rr_ptr_nxt;
      owner    <= owner_nxt;
      beat_cnt <= beat_cnt_nxt;
    end
  end

endmodule

// File: tb/tb_fifo_push_arbiter.sv
// Scoreboard bench for fifo_push_arbiter in front of a depth-4 FIFO model.
module tb_fifo_push_arbiter;

  localparam int unsigned NREQ      = 3;
  localparam int unsigned DATA_W    = 8;
  localparam int unsigned MAX_BURST = 4;
  localparam int unsigned IDX_W     = 2;
  localparam int unsigned DEPTH     = 4;

  typedef struct packed {
    logic [7:0] data;
    logic [1:0] gid;
  } exp_t;

  logic                   clk = 1'b0;
  logic                   reset;
  logic [NREQ-1:0]        req_valid;
  logic [NREQ-1:0]        req_last;
  logic [NREQ*DATA_W-1:0] req_data;
  logic [NREQ-1:0]        req_ready;
  logic                   fifo_full = 1'b0;
  logic                   push;
  logic [DATA_W-1:0]      push_data;
  logic [IDX_W-1:0]       grant_id;

  exp_t       exp_q[$];
  logic [7:0] pop_q[$];
  logic [7:0] fifo_q[$];
  exp_t       mon_e;
  logic [7:0] popped;
  logic [7:0] pop_exp;
  logic       s_push = 1'b0;
  logic [7:0] s_data = '0;
  logic       pop_req = 1'b0;

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  fifo_push_arbiter #(
    .NREQ     (NREQ),
    .DATA_W   (DATA_W),
    .MAX_BURST(MAX_BURST)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid_i(req_valid),
    .req_last_i (req_last),
    .req_data_i (req_data),
    .req_ready_o(req_ready),
    .fifo_full_i(fifo_full),
    .push_o     (push),
    .push_data_o(push_data),
    .grant_id_o (grant_id)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act === req) passes++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
  endtask

  task automatic cyc(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_push(input logic [7:0] d, input logic [1:0] g);
    exp_t x;
    x.data = d;
    x.gid  = g;
    exp_q.push_back(x);
    pop_q.push_back(d);
  endtask

  task automatic drain_check(input string tag);
    check({tag, "_push_left"}, 32'(exp_q.size()), 0);
    check({tag, "_pop_left"}, 32'(pop_q.size()), 0);
  endtask

  task automatic stall_check(input string tag);
    @(negedge clk);
    check({tag, "_push"}, 32'(push), 0);
    check({tag, "_ready"}, 32'(req_ready), 0);
  endtask

  // Monitor: every push seen by the FIFO is matched against the scoreboard.
  always @(negedge clk) begin
    s_push = push;
    s_data = push_data;
    if (reset) begin
      if (push) begin
        check("push_expected", 32'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          mon_e = exp_q.pop_front();
          check("push_data", 32'(push_data), 32'(mon_e.data));
          check("grant_id", 32'(grant_id), 32'(mon_e.gid));
          check("ready_onehot", 32'(req_ready), 32'(1) << mon_e.gid);
        end
      end else begin
        check("idle_ready", 32'(req_ready), 0);
        check("idle_data", 32'(push_data), 0);
      end
    end
  end

  // Depth-4 FIFO model: pop existing entry first, then take the push.
  always @(posedge clk) begin
    if (pop_req && fifo_q.size() > 0) begin
      popped = fifo_q.pop_front();
      check("pop_expected", 32'(pop_q.size() != 0), 1);
      if (pop_q.size() != 0) begin
        pop_exp = pop_q.pop_front();
        check("pop_data", 32'(popped), 32'(pop_exp));
      end
    end
    if (s_push) fifo_q.push_back(s_data);
    fifo_full <= (fifo_q.size() >= DEPTH);
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got %0d/%0d", passes, checks);
    $fatal(1);
  end

  initial begin
    reset     = 1'b0;
    req_valid = 3'b111;
    req_last  = 3'b000;
    req_data  = {8'hC0, 8'hB0, 8'hA0};

    // Reset held with every requester valid: nothing may leak through.
    repeat (3) begin
      @(negedge clk);
      check("rst_push", 32'(push), 0);
      check("rst_ready", 32'(req_ready), 0);
      check("rst_gid", 32'(grant_id), 0);
      check("rst_data", 32'(push_data), 0);
    end
    cyc();

    // Fairness: all valid, grants rotate 0,1,2,0.
    expect_push(8'hA0, 2'd0);
    expect_push(8'hB0, 2'd1);
    expect_push(8'hC0, 2'd2);
    expect_push(8'hA0, 2'd0);
    pop_req = 1'b1;
    reset   = 1'b1;
    cyc(4);
    req_valid = 3'b000;
    cyc(2);
    drain_check("fair");

    // Full stall: fill with four req0 beats, then req1 waits for space.
    pop_req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      req_valid = 3'b001;
      req_data  = {8'h00, 8'h00, 8'(8'h10 + i)};
      expect_push(8'(8'h10 + i), 2'd0);
      cyc();
    end
    req_valid = 3'b010;
    req_data  = {8'h00, 8'h55, 8'h00};
    repeat (3) stall_check("full");
    cyc();
    expect_push(8'h55, 2'd1);
    pop_req = 1'b1;
    cyc();
    pop_req = 1'b0;
    cyc();
    req_valid = 3'b000;
    cyc(2);
    pop_req = 1'b1;
    cyc(5);
    drain_check("full");

    // Wrap: pointer at 2 after req1 won.
    req_valid = 3'b101;
    req_data  = {8'h22, 8'h00, 8'h20};
    expect_push(8'h22, 2'd2);
    cyc();
    req_data = {8'h23, 8'h00, 8'h20};
    expect_push(8'h20, 2'd0);
    cyc();
    req_valid = 3'b001;
    req_data  = {8'h00, 8'h00, 8'h30};
    expect_push(8'h30, 2'd0);
    cyc();
    req_valid = 3'b111;
    req_data  = {8'hC1, 8'hB1, 8'hA1};
    expect_push(8'hB1, 2'd1);
    cyc();
    req_valid = 3'b000;
    cyc(2);
    drain_check("wrap");

    // Mid-operation reset: pointer returns to 0, req0 wins first.
    req_valid = 3'b111;
    req_data  = {8'hC2, 8'hB2, 8'hA2};
    reset     = 1'b0;
    repeat (2) begin
      @(negedge clk);
      check("midrst_push", 32'(push), 0);
      check("midrst_ready", 32'(req_ready), 0);
      check("midrst_gid", 32'(grant_id), 0);
    end
    cyc();
    reset = 1'b1;
    expect_push(8'hA2, 2'd0);
    cyc();
    req_valid = 3'b000;
    cyc(2);
    drain_check("midrst");

`ifdef FIFO_ARB_BURST_EN
    // Burst: req0 locks for four beats, req1 gets one, req0 resumes.
    reset = 1'b0;
    cyc();
    reset     = 1'b1;
    req_last  = 3'b010;
    req_valid = 3'b011;
    for (int i = 0; i < 4; i++) begin
      req_data = {8'h00, 8'h51, 8'(8'h40 + i)};
      expect_push(8'(8'h40 + i), 2'd0);
      cyc();
    end
    req_data = {8'h00, 8'h51, 8'h44};
    expect_push(8'h51, 2'd1);
    cyc();
    req_valid = 3'b001;
    expect_push(8'h44, 2'd0);
    cyc();
    req_last = 3'b011;
    req_data = {8'h00, 8'h00, 8'h45};
    expect_push(8'h45, 2'd0);
    cyc();
    req_valid = 3'b000;
    req_last  = 3'b000;
    cyc(2);
    drain_check("burst");
`endif

    pop_req = 1'b0;
    cyc(2);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
